// File: rtl/core_pkg.sv
// Shared RV32I core types and constants: XLEN, reset PC, AXI read responses, fetch state.
// No logic; pure declarations.
// Not applicable (no handshakes in a package).
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // AXI read response codes
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_ADDR,
    FS_DATA,
    FS_DROP,
    FS_HALT
  } fetch_state_t;

  // One instruction buffer entry: fetch PC in the upper half, word in the lower half.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head data is read straight from registers.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is accepted only when not full, or when full and popping in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch: owns the PC, issues single-beat AXI reads, buffers {pc,inst} for decode; optional INST_FETCH_RESP_CHECK_EN halts on bad RRESP.
// Latency: zero-wait slave gives one word per 3 cycles; INST_VALID rises the cycle after the R handshake.
// Backpressure: no new read is issued while the buffer is full; ARVALID is held until ARREADY.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CCLK,
  input  logic        CRST,
  input  logic        CEXEC,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_DATA,
  output logic [31:0] INST_PC,
  output logic [31:0] CUR_PC,
  output logic [31:0] M_INST_AXI_ARADDR,
  output logic        M_INST_AXI_ARVALID,
  input  logic        M_INST_AXI_ARREADY,
  input  logic [31:0] M_INST_AXI_RDATA,
  input  logic [1:0]  M_INST_AXI_RRESP,
  input  logic        M_INST_AXI_RLAST,
  input  logic        M_INST_AXI_RVALID,
  output logic        M_INST_AXI_RREADY,
  output logic        FETCH_ERR
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  araddr_q;
  logic         drop_pend;
  logic         redirect_act;
  logic [31:0]  redirect_tgt;
  logic         issue;
  logic         push;
  logic         flush;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         fifo_full;
  logic         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef INST_FETCH_RESP_CHECK_EN
  logic         resp_err;
  logic         fetch_err_q;
`endif

  // Halted fetch ignores redirects entirely; otherwise a redirect always flushes.
  assign redirect_act = REDIRECT_VALID && (state != FS_HALT);
  assign redirect_tgt = {REDIRECT_PC[31:2], 2'b00};
  assign flush        = redirect_act;
  assign pop          = INST_VALID && INST_READY;

  assign push_entry.pc   = pc;
  assign push_entry.inst = M_INST_AXI_RDATA;

  assign INST_VALID        = !fifo_empty;
  assign INST_DATA         = head_entry.inst;
  assign INST_PC           = head_entry.pc;
  assign CUR_PC            = pc;
  assign M_INST_AXI_ARADDR = araddr_q;

  // Next-state and handshake outputs; a redirect outranks a coincident R beat.
  always_comb begin
    state_nxt          = state;
    issue              = 1'b0;
    push               = 1'b0;
    M_INST_AXI_ARVALID = 1'b0;
    M_INST_AXI_RREADY  = 1'b0;
`ifdef INST_FETCH_RESP_CHECK_EN
    resp_err           = 1'b0;
`endif
    case (state)
      FS_IDLE: begin
        if (CEXEC && !REDIRECT_VALID && !fifo_full) begin
          issue     = 1'b1;
          state_nxt = FS_ADDR;
        end
      end
      FS_ADDR: begin
        M_INST_AXI_ARVALID = 1'b1;
        if (M_INST_AXI_ARREADY) begin
          state_nxt = (drop_pend || redirect_act) ? FS_DROP : FS_DATA;
        end
      end
      FS_DATA: begin
        M_INST_AXI_RREADY = 1'b1;
        if (redirect_act) begin
          // The beat, if present now, is consumed here and thrown away.
          state_nxt = M_INST_AXI_RVALID ? FS_IDLE : FS_DROP;
        end else if (M_INST_AXI_RVALID) begin
`ifdef INST_FETCH_RESP_CHECK_EN
          if (M_INST_AXI_RRESP != RRESP_OKAY) begin
            resp_err  = 1'b1;
            state_nxt = FS_HALT;
          end else
`endif
          begin
            push      = 1'b1;
            state_nxt = FS_IDLE;
          end
        end
      end
      FS_DROP: begin
        M_INST_AXI_RREADY = 1'b1;
        if (M_INST_AXI_RVALID) state_nxt = FS_IDLE;
      end
      FS_HALT: begin
        state_nxt = FS_HALT;
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) state <= FS_IDLE;
    else      state <= state_nxt;
  end

  // PC, latched read address, and the "redirect seen while waiting on ARREADY" marker.
  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      pc        <= RESET_PC;
      araddr_q  <= '0;
      drop_pend <= 1'b0;
    end else begin
      if (issue) araddr_q <= pc;
      if (redirect_act)  pc <= redirect_tgt;
      else if (push)     pc <= pc + 32'd4;
      if (state == FS_ADDR && !M_INST_AXI_ARREADY) drop_pend <= drop_pend || redirect_act;
      else                                          drop_pend <= 1'b0;
    end
  end

`ifdef INST_FETCH_RESP_CHECK_EN
  // Sticky bus-error flag, cleared only by reset.
  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST)          fetch_err_q <= 1'b0;
    else if (resp_err) fetch_err_q <= 1'b1;
  end
  assign FETCH_ERR = fetch_err_q;
`else
  assign FETCH_ERR = 1'b0;
`endif

  // RLAST is always 1 for single-beat reads; RRESP matters only with response checking.
  logic unused_ok;
  assign unused_ok = ^{M_INST_AXI_RLAST, M_INST_AXI_RRESP, fifo_count};

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CCLK),
    .rst      (CRST),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (flush),
    .pop_dat  (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RV32I core. It owns the program counter and issues single-beat 32-bit reads on the core's instruction AXI master (AR/R channels only). It buffers returned instruction words with their PCs in a small FIFO and hands them to decode over a valid/ready interface. Branch/jump redirects from execute flush the buffer and discard any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)

Ports:
- CCLK  in  1  core clock; all logic on rising edge
- CRST  in  1  reset, asynchronous, active-high
- CEXEC  in  1  run enable; new fetches issue only while high
- REDIRECT_VALID  in  1  execute requests PC change (one-cycle pulse)
- REDIRECT_PC  in  32  target PC; bits [1:0] ignored, forced 00
- INST_VALID  out  1  FIFO head valid
- INST_READY  in  1  decode accepts head
- INST_DATA  out  32  instruction word at head
- INST_PC  out  32  PC of head instruction
- CUR_PC  out  32  next fetch PC (debug, drives REGPC)
- M_INST_AXI_ARADDR  out  32  read address
- M_INST_AXI_ARVALID  out  1  read address valid
- M_INST_AXI_ARREADY  in  1  read address ready
- M_INST_AXI_RDATA  in  32  read data
- M_INST_AXI_RRESP  in  2  read response
- M_INST_AXI_RLAST  in  1  last beat (always expected 1; not checked)
- M_INST_AXI_RVALID  in  1  read data valid
- M_INST_AXI_RREADY  out  1  read data ready
- FETCH_ERR  out  1  sticky bus-error flag

## Operation
- FSM states: IDLE, ADDR, DATA, DROP, HALT. One outstanding read max; ARLEN=0, ARSIZE=010 fixed in the core.
- IDLE→ADDR when CEXEC=1, no redirect this cycle, and FIFO count < FIFO_DEPTH. ARADDR latched = pc.
- ADDR: ARVALID=1, ARADDR stable until ARREADY. On handshake → DATA, or → DROP if a redirect arrived in ADDR or in the handshake cycle. ARVALID is never withdrawn before handshake.
- DATA: RREADY=1. On RVALID: push {pc, RDATA}, pc ← pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC→0), → IDLE.
- DROP: RREADY=1; on RVALID discard data, → IDLE.
- Redirect (any state except HALT): FIFO flushed same edge, pc ← {REDIRECT_PC[31:2],2'b00}. DATA → DROP. Redirect beats a coincident R handshake: that word is discarded, pc not incremented.
- FIFO: push and pop in the same cycle allowed when count ≥1; pop when INST_VALID&&INST_READY. A simultaneous flush empties the FIFO.
- CEXEC low mid-transaction: current read completes and is pushed normally; no new issue.

## Timing
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, INST_VALID=0, INST_DATA=0, INST_PC=0, FETCH_ERR=0, CUR_PC=RESET_PC, state IDLE, FIFO empty.
- ARVALID rises the cycle after IDLE issue condition holds.
- INST_VALID rises the cycle after the R handshake (registered FIFO output).
- Best case with zero-wait slave: one instruction per 3 cycles.
- Reset asserted mid-transaction: all state cleared immediately; any later RVALID from the pre-reset read is outside spec (system resets slave too).

## Configuration
- INST_FETCH_RESP_CHECK_EN defined: in DATA, RRESP≠2'b00 → word not pushed, FETCH_ERR←1 (sticky), → HALT. HALT issues nothing, ignores redirect, holds until CRST.
- Undefined: RRESP ignored, every response pushed, FETCH_ERR tied 0, HALT unreachable.

## Structure
- Shared package core_pkg: RESET_PC default, XLEN=32, AXI RRESP codes (OKAY/EXOKAY/SLVERR/DECERR), fetch state enum.
- Sub-module fetch_fifo: synchronous FIFO, width 64 ({pc,inst}), depth FIFO_DEPTH, ports push/pop/flush/full/empty/count.

## Test plan
- Reset, CEXEC=1, zero-wait slave returning addr^32'hA5A5_0000 → INST_PC sequence 0,4,8 with matching INST_DATA; ARVALID first high 1 cycle after reset release.
- INST_READY=0, FIFO_DEPTH=2 → exactly 2 reads issued, ARVALID stays 0; INST_READY=1 resumes at PC 8.
- Redirect to 32'h0000_0103 while in DATA → in-flight word dropped, FIFO empty, next ARADDR=32'h0000_0100.
- Slave delays ARREADY 5 cycles with redirect at cycle 2 → ARVALID/ARADDR stable to handshake, response discarded, next fetch at target.
- RESET_PC=32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000.
- With INST_FETCH_RESP_CHECK_EN, RRESP=SLVERR at PC 4 → FETCH_ERR=1, no push of PC 4, no further ARVALID until CRST.
